spi_ram: RTL and testbench

SPI_RAM -- requirements
Module: spi_ram

---
 rtl/spi_ram.sv | 134 +++++++++++++
 tb/tb_spi_ram.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram.sv
// -----------------------------------------------------------------------------
// spi_ram
//   Byte-wide RAM that sits behind an SPI slave front end. The slave hands over
//   one 10-bit command word per frame. Bits [9:8] hold the opcode and bits
//   [7:0] hold the payload.
//     00 : load write address          01 : write payload at write address
//     10 : load read address           11 : read byte at read address
//   A data command that arrives before its matching address command is
//   rejected with a one-cycle cmd_err pulse.
//
//   Optional feature: define SPI_RAM_AUTOINC_EN to post-increment the
//   write/read address after every successful data command. The address
//   wraps modulo MEM_DEPTH.
//
// Parameters
//   MEM_DEPTH : number of 8-bit words, must equal 2**ADDR_SIZE
//   ADDR_SIZE : address width
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset (memory contents are kept)
//   rx_valid in   one-cycle frame strobe from the SPI slave
//   rx_data  in   [9:8] opcode, [7:0] payload
//   tx_valid out  one-cycle pulse, tx_data holds a fresh read byte
//   tx_data  out  last byte read, held until the next successful read
//   cmd_err  out  one-cycle pulse for a data command issued while unarmed
// -----------------------------------------------------------------------------
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [9:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_t;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_armed;
  logic                 rd_armed;

  opcode_t              opcode;
  logic [7:0]           payload;
  logic                 do_write;
  logic                 do_read;

  assign opcode  = opcode_t'(rx_data[9:8]);
  assign payload = rx_data[7:0];

  // Reset wins over a frame strobe on the same edge, so both data strobes are
  // qualified with !rst. The memory array itself is never reset.
  assign do_write = !rst && rx_valid && (opcode == OP_WR_DATA) && wr_armed;
  assign do_read  = !rst && rx_valid && (opcode == OP_RD_DATA) && rd_armed;

  // Storage array. It is kept apart from the control registers so that it
  // maps onto a plain RAM with no reset port. A read on the very next frame
  // sees the new byte because the write completes on this edge.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= payload;
    end
  end

  // Command decoder. It holds the address registers, the arm flags and the
  // registered outputs. The tx_valid and cmd_err outputs default low every
  // cycle, which makes them single-cycle pulses. The tx_data output is only
  // loaded on a successful read, so it holds its value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      cmd_err  <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      if (rx_valid) begin
        unique case (opcode)
          OP_WR_ADDR: begin
            wr_addr  <= rx_data[ADDR_SIZE-1:0];
            wr_armed <= 1'b1;
          end
          OP_WR_DATA: begin
            if (wr_armed) begin
`ifdef SPI_RAM_AUTOINC_EN
              wr_addr <= wr_addr + ADDR_SIZE'(1);
`else
              wr_addr <= wr_addr;
`endif
            end else begin
              cmd_err <= 1'b1;
            end
          end
          OP_RD_ADDR: begin
            rd_addr  <= rx_data[ADDR_SIZE-1:0];
            rd_armed <= 1'b1;
          end
          OP_RD_DATA: begin
            if (rd_armed) begin
              tx_data  <= mem[rd_addr];
              tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
              rd_addr  <= rd_addr + ADDR_SIZE'(1);
`else
              rd_addr  <= rd_addr;
`endif
            end else begin
              cmd_err <= 1'b1;
            end
          end
          default: begin
            cmd_err <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram.sv
// -----------------------------------------------------------------------------
// tb_spi_ram
//   Self-checking bench for spi_ram. A transaction-level model holds a byte
//   array and the two address pointers. On every clock, the bench predicts
//   tx_valid, tx_data and cmd_err from that model. A compare process then
//   checks the DUT on each falling edge. Literal expectations pin the key
//   scenarios.
// -----------------------------------------------------------------------------
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       cmd_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_ram dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .cmd_err  (cmd_err)
  );

  // Reference model state: a byte array with a "known" flag per word. The
  // DUT memory powers up undefined, so a read of a never-written word is not
  // checked for its data value.
  logic [7:0] m_mem   [256];
  bit         m_known [256];
  logic [7:0] m_waddr;
  logic [7:0] m_raddr;
  bit         m_warm;
  bit         m_rarm;
  logic       exp_valid = 1'b0;
  logic       exp_err   = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  bit         exp_data_known = 1'b0;
  bit         checking = 1'b0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Predict the result of one clock edge directly from the command meaning.
  task automatic modelStep(input logic r, input logic v, input logic [9:0] d);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (r) begin
      m_waddr = 8'h00;
      m_raddr = 8'h00;
      m_warm  = 1'b0;
      m_rarm  = 1'b0;
      exp_data = 8'h00;
      exp_data_known = 1'b1;
    end else if (v) begin
      case (d[9:8])
        2'b00: begin
          m_waddr = d[7:0];
          m_warm  = 1'b1;
        end
        2'b01: begin
          if (m_warm) begin
            m_mem[m_waddr]   = d[7:0];
            m_known[m_waddr] = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            m_waddr = m_waddr + 8'd1;
`endif
          end else begin
            exp_err = 1'b1;
          end
        end
        2'b10: begin
          m_raddr = d[7:0];
          m_rarm  = 1'b1;
        end
        default: begin
          if (m_rarm) begin
            exp_valid      = 1'b1;
            exp_data       = m_mem[m_raddr];
            exp_data_known = m_known[m_raddr];
`ifdef SPI_RAM_AUTOINC_EN
            m_raddr = m_raddr + 8'd1;
`endif
          end else begin
            exp_err = 1'b1;
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then advance the model at
  // the rising edge that consumes them.
  task automatic applyStimulus(input logic r, input logic v, input logic [9:0] d);
    @(negedge clk);
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    modelStep(r, v, d);
  endtask

  // Compare the DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("tx_valid", {7'b0, tx_valid}, {7'b0, exp_valid});
      checkOutput("cmd_err", {7'b0, cmd_err}, {7'b0, exp_err});
      if (exp_data_known) begin
        checkOutput("tx_data", tx_data, exp_data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 10'h000;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

    // Reset for two cycles, then check the cleared outputs.
    applyStimulus(1'b1, 1'b0, 10'h000);
    checking = 1'b1;
    applyStimulus(1'b1, 1'b0, 10'h000);
    #1;
    checkOutput("reset_tx_data", tx_data, 8'h00);
    checkOutput("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    checkOutput("reset_cmd_err", {7'b0, cmd_err}, 8'h00);

    // Basic write then read.
    applyStimulus(1'b0, 1'b1, 10'h012);
    applyStimulus(1'b0, 1'b1, 10'h1A5);
    applyStimulus(1'b0, 1'b1, 10'h212);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
    checkOutput("basic_read_valid", {7'b0, tx_valid}, 8'h01);
    checkOutput("basic_read_data", tx_data, 8'hA5);
    checkOutput("model_mem_12", m_mem[8'h12], 8'hA5);
    applyStimulus(1'b0, 1'b0, 10'h000);
    #1;
    checkOutput("valid_is_pulse", {7'b0, tx_valid}, 8'h00);
    checkOutput("data_holds", tx_data, 8'hA5);

    // Put a known byte at address 0, then check out-of-sequence commands after reset.
    applyStimulus(1'b0, 1'b1, 10'h000);
    applyStimulus(1'b0, 1'b1, 10'h133);
    applyStimulus(1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b1, 10'h155);
    #1;
    checkOutput("unarmed_write_err", {7'b0, cmd_err}, 8'h01);
    applyStimulus(1'b0, 1'b0, 10'h000);
    #1;
    checkOutput("err_is_pulse", {7'b0, cmd_err}, 8'h00);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
    checkOutput("unarmed_read_err", {7'b0, cmd_err}, 8'h01);
    checkOutput("unarmed_read_novalid", {7'b0, tx_valid}, 8'h00);
    applyStimulus(1'b0, 1'b1, 10'h200);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
    checkOutput("rejected_write_kept_mem", tx_data, 8'h33);

    // Memory is retained across reset.
    applyStimulus(1'b0, 1'b1, 10'h040);
    applyStimulus(1'b0, 1'b1, 10'h15A);
    applyStimulus(1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b1, 10'h240);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
    checkOutput("mem_kept_over_reset", tx_data, 8'h5A);

    // A reset between the address and data commands disarms the write.
    applyStimulus(1'b0, 1'b1, 10'h010);
    applyStimulus(1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b1, 10'h177);
    #1;
    checkOutput("reset_disarms_write", {7'b0, cmd_err}, 8'h01);

    // Reset on the same edge as a read strobe wins.
    applyStimulus(1'b0, 1'b1, 10'h240);
    applyStimulus(1'b1, 1'b1, 10'h300);
    #1;
    checkOutput("rst_over_read_valid", {7'b0, tx_valid}, 8'h00);
    checkOutput("rst_over_read_data", tx_data, 8'h00);

    // A write followed by a read on back-to-back frames returns the new byte.
    applyStimulus(1'b0, 1'b1, 10'h080);
    applyStimulus(1'b0, 1'b1, 10'h280);
    applyStimulus(1'b0, 1'b1, 10'h1C3);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
    checkOutput("b2b_read_1", tx_data, 8'hC3);
    applyStimulus(1'b0, 1'b1, 10'h13C);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
    checkOutput("b2b_read_2", tx_data, 8'h3C);

    // The write path leaves the read address alone.
    applyStimulus(1'b0, 1'b1, 10'h212);
    applyStimulus(1'b0, 1'b1, 10'h055);
    applyStimulus(1'b0, 1'b1, 10'h199);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
    checkOutput("addr_independent", tx_data, 8'hA5);

    // Address overwrite, plus idle cycles that carry a stale read word.
    applyStimulus(1'b0, 1'b1, 10'h020);
    applyStimulus(1'b0, 1'b1, 10'h021);
    applyStimulus(1'b0, 1'b1, 10'h144);
    applyStimulus(1'b0, 1'b0, 10'h300);
    applyStimulus(1'b0, 1'b0, 10'h300);
    #1;
    checkOutput("idle_no_valid", {7'b0, tx_valid}, 8'h00);
    applyStimulus(1'b0, 1'b1, 10'h221);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
    checkOutput("addr_overwrite", tx_data, 8'h44);

    // Two data commands from address 0xFF.
    applyStimulus(1'b0, 1'b1, 10'h0FF);
    applyStimulus(1'b0, 1'b1, 10'h111);
    applyStimulus(1'b0, 1'b1, 10'h122);
    applyStimulus(1'b0, 1'b1, 10'h2FF);
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
`ifdef SPI_RAM_AUTOINC_EN
    checkOutput("wrap_read_ff", tx_data, 8'h11);
`else
    checkOutput("same_addr_read_1", tx_data, 8'h22);
`endif
    applyStimulus(1'b0, 1'b1, 10'h300);
    #1;
`ifdef SPI_RAM_AUTOINC_EN
    checkOutput("wrap_read_00", tx_data, 8'h22);
    checkOutput("model_mem_00", m_mem[8'h00], 8'h22);
`else
    checkOutput("same_addr_read_2", tx_data, 8'h22);
    checkOutput("model_mem_00", m_mem[8'h00], 8'h33);
`endif
    applyStimulus(1'b0, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b0, 10'h000);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
